// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC owner, in-order imem requester, prefetch FIFO.
// Optional perf counters under `FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [DW-1:0]  RESET_PC = '0,
  parameter int unsigned    INC      = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_ready_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  input  logic          stall_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] instr_o,
  output logic [DW-1:0] pc_o,
  output logic          empty_o,
  output logic          full_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   fetched_cnt_o,
  output logic [31:0]   discarded_cnt_o,
  output logic [31:0]   redirect_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPC = CW'(DEPTH);
  localparam logic [CW:0]   DEP1 = (CW+1)'(DEPTH);

  logic [DW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] hd_q, hd_d;
  logic [AW-1:0] tl_q, tl_d;
  logic [AW-1:0] iwr_q, iwr_d;
  logic [AW-1:0] ird_q, ird_d;

  logic [DW-1:0] fpc_q  [DEPTH];
  logic [DW-1:0] fins_q [DEPTH];
  logic [DW-1:0] ipc_q  [DEPTH];

  logic          fire;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW:0]   credit;

  // Requests reserve a FIFO slot up front so responses never overflow.
  assign credit      = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_o  = !rst && !stall_i && !redirect_i
                       && (credit < DEP1);
  assign imem_addr_o = pc_q;

  assign fire = imem_req_o && imem_ready_i;
  assign rsp  = imem_rvalid_i && (out_q != '0);
  assign drop = rsp && (redirect_i || (disc_q != '0));
  assign push = rsp && !drop;
  assign pop  = valid_o && ready_i && !redirect_i;

  assign valid_o = (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPC);
  assign instr_o = valid_o ? fins_q[hd_q] : '0;
  assign pc_o    = valid_o ? fpc_q[hd_q]  : '0;

  always_comb begin
    pc_d   = fire ? pc_q + DW'(INC) : pc_q;
    out_d  = out_q + CW'(fire) - CW'(rsp);
    iwr_d  = iwr_q + AW'(fire);
    ird_d  = ird_q + AW'(rsp);
    hd_d   = hd_q + AW'(pop);
    tl_d   = tl_q + AW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    disc_d = disc_q - CW'(rsp && (disc_q != '0));
    if (redirect_i) begin
      pc_d   = redirect_pc_i;
      hd_d   = '0;
      tl_d   = '0;
      cnt_d  = '0;
      disc_d = out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      out_q  <= '0;
      disc_q <= '0;
      hd_q   <= '0;
      tl_q   <= '0;
      iwr_q  <= '0;
      ird_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      iwr_q  <= iwr_d;
      ird_q  <= ird_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[tl_q]  <= ipc_q[ird_q];
      fins_q[tl_q] <= imem_rdata_i;
    end
    if (fire) begin
      ipc_q[iwr_q] <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fet_q;
  logic [31:0] dis_q;
  logic [31:0] red_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fet_q <= '0;
      dis_q <= '0;
      red_q <= '0;
    end else begin
      fet_q <= fet_q + 32'(pop);
      dis_q <= dis_q + 32'(drop);
      red_q <= red_q + 32'(redirect_i);
    end
  end

  assign fetched_cnt_o   = fet_q;
  assign discarded_cnt_o = dis_q;
  assign redirect_cnt_o  = red_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        empty_o;
  logic        full_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_empty;
  logic        w_full;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_cnt_o;
  logic [31:0] discarded_cnt_o;
  logic [31:0] redirect_cnt_o;
  logic [31:0] w_fc;
  logic [31:0] w_dc;
  logic [31:0] w_rc;
`endif

  fetch_unit #(.DW(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .INC(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .empty_o(empty_o), .full_o(full_o)
`ifdef FETCH_PERF_EN
    , .fetched_cnt_o(fetched_cnt_o)
    , .discarded_cnt_o(discarded_cnt_o)
    , .redirect_cnt_o(redirect_cnt_o)
`endif
  );

  fetch_unit #(.DW(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .INC(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(1'b1), .imem_rvalid_i(w_rvalid),
    .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .stall_i(1'b0), .valid_o(w_valid), .ready_i(1'b1),
    .instr_o(w_instr), .pc_o(w_pc), .empty_o(w_empty), .full_o(w_full)
`ifdef FETCH_PERF_EN
    , .fetched_cnt_o(w_fc)
    , .discarded_cnt_o(w_dc)
    , .redirect_cnt_o(w_rc)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a * 32'd7);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] a;
  } mrsp_t;

  // reference model
  logic [31:0] m_pc;
  ent_t        m_fifo[$];
  logic [31:0] m_infl[$];
  int          m_disc, m_fet, m_drop, m_red;

  // memory model and logs
  mrsp_t       mq[$];
  int          cyc, last_due, lat_min, lat_max;
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] w_pop_log[$];
  logic        w_fire_prev;
  logic [31:0] w_addr_prev;

  logic        s_req, s_valid, s_empty, s_full;
  logic [31:0] s_addr, s_pc, s_instr;

  int n_vec, n_bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_fifo.delete();
    m_infl.delete();
    m_disc = 0;
    m_fet  = 0;
    m_drop = 0;
    m_red  = 0;
  endtask

  task automatic cycle();
    bit          e_req;
    int          due;
    logic [31:0] a;
    @(negedge clk);
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = valid_o;
    s_empty = empty_o;
    s_full  = full_o;
    s_pc    = pc_o;
    s_instr = instr_o;
    e_req = !rst && !stall_i && !redirect_i
            && (m_fifo.size() + m_infl.size() < DEPTH);
    chk("req", imem_req_o, e_req);
    if (e_req) chk("addr", imem_addr_o, m_pc);
    chk("valid", valid_o, m_fifo.size() != 0);
    chk("empty", empty_o, m_fifo.size() == 0);
    chk("full", full_o, m_fifo.size() == DEPTH);
    if (m_fifo.size() != 0) begin
      chk("pc", pc_o, m_fifo[0].pc);
      chk("instr", instr_o, m_fifo[0].ins);
    end
`ifdef FETCH_PERF_EN
    chk("fetched_cnt", fetched_cnt_o, m_fet);
    chk("discarded_cnt", discarded_cnt_o, m_drop);
    chk("redirect_cnt", redirect_cnt_o, m_red);
`endif
    if (!rst && w_valid) begin
      w_pop_log.push_back(w_pc);
      chk("wrap_instr", w_instr, memf(w_pc));
    end
    if (imem_req_o && imem_ready_i) begin
      fire_log.push_back(imem_addr_o);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due, imem_addr_o});
    end
    if (!rst && valid_o && ready_i && !redirect_i) pop_log.push_back(pc_o);
    w_fire_prev = w_req;
    w_addr_prev = w_addr;
    if (rst) begin
      model_reset();
    end else begin
      if (m_fifo.size() != 0 && ready_i && !redirect_i) begin
        void'(m_fifo.pop_front());
        m_fet++;
      end
      if (imem_rvalid_i && m_infl.size() != 0) begin
        a = m_infl.pop_front();
        if (redirect_i || m_disc > 0) begin
          if (m_disc > 0) m_disc--;
          m_drop++;
        end else begin
          m_fifo.push_back('{a, memf(a)});
        end
      end
      if (e_req && imem_ready_i) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (redirect_i) begin
        m_fifo.delete();
        m_pc   = redirect_pc_i;
        m_disc = m_infl.size();
        m_red++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
      last_due      = -1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      w_rvalid      = 1'b0;
      w_rdata       = 32'h0;
    end else begin
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memf(mq[0].a);
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      w_rvalid = w_fire_prev;
      w_rdata  = memf(w_addr_prev);
    end
  endtask

  task automatic rst_cycle();
    rst        = 1'b1;
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    cycle();
    rst = 1'b0;
    fire_log.delete();
    pop_log.delete();
    w_pop_log.delete();
  endtask

  typedef struct {
    bit          rst;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; last_due = -1;
    rst = 1'b1; imem_ready_i = 1'b1; imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    stall_i = 1'b0; ready_i = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_fire_prev = 1'b0; w_addr_prev = 32'h0;
    lat_min = 1; lat_max = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: reset then 1-cycle memory, decode always ready
    vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h4};
    vecs[5] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[6] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hC};
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      cycle();
      chk($sformatf("t1_req[%0d]", i), s_req, vecs[i].req);
      if (vecs[i].req) chk($sformatf("t1_addr[%0d]", i), s_addr, vecs[i].addr);
      chk($sformatf("t1_valid[%0d]", i), s_valid, vecs[i].valid);
      chk($sformatf("t1_pc[%0d]", i), s_pc, vecs[i].pc);
      chk($sformatf("t1_instr[%0d]", i), s_instr,
          vecs[i].valid ? memf(vecs[i].pc) : 32'h0);
    end

    // 2: decode blocked fills exactly DEPTH entries, then drains in order
    rst_cycle();
    ready_i = 1'b0;
    repeat (8) cycle();
    chk("t2_nfire", fire_log.size(), 4);
    for (int i = 0; i < 4 && i < fire_log.size(); i++)
      chk($sformatf("t2_fire[%0d]", i), fire_log[i], 32'(4 * i));
    chk("t2_full", s_full, 1'b1);
    chk("t2_req", s_req, 1'b0);
    ready_i = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      chk($sformatf("t2_pop[%0d]", i), pop_log[i], 32'(4 * i));
    chk("t2_npop", pop_log.size() >= 4, 1'b1);
    if (fire_log.size() > 4) chk("t2_resume", fire_log[4], 32'h10);
    else chk("t2_resume", fire_log.size(), 5);

    // 3: latency 3, two in flight, redirect drops both
    lat_min = 3; lat_max = 3;
    rst_cycle();
    cycle();
    cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle();
    chk("t3_req_on_redir", s_req, 1'b0);
    redirect_i = 1'b0;
    repeat (10) cycle();
    chk("t3_npop", pop_log.size() >= 2, 1'b1);
    if (pop_log.size() >= 2) begin
      chk("t3_pop0", pop_log[0], 32'h100);
      chk("t3_pop1", pop_log[1], 32'h104);
    end
`ifdef FETCH_PERF_EN
    chk("t3_discarded", discarded_cnt_o, 32'd2);
`endif

    // 4: redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    rst_cycle();
    repeat (6) cycle();
    chk("t4_rvalid_pre", imem_rvalid_i, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    pop_log.delete();
    cycle();
    chk("t4_valid_at_redir", s_valid, 1'b1);
    redirect_i = 1'b0;
    cycle();
    chk("t4_valid", s_valid, 1'b0);
    chk("t4_empty", s_empty, 1'b1);
    chk("t4_req", s_req, 1'b1);
    chk("t4_addr", s_addr, 32'h200);
    repeat (4) cycle();
    if (pop_log.size() != 0) chk("t4_pop0", pop_log[0], 32'h200);
    else chk("t4_npop", 0, 1);

    // 5: PC wrap from RESET_PC = FFFFFFF8
    rst_cycle();
    repeat (6) cycle();
    chk("t5_npop", w_pop_log.size() >= 3, 1'b1);
    if (w_pop_log.size() >= 3) begin
      chk("t5_pop0", w_pop_log[0], 32'hFFFF_FFF8);
      chk("t5_pop1", w_pop_log[1], 32'hFFFF_FFFC);
      chk("t5_pop2", w_pop_log[2], 32'h0000_0000);
    end

    // 6: reset mid-burst with three outstanding
    lat_min = 3; lat_max = 3;
    rst_cycle();
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t6_valid", s_valid, 1'b0);
    chk("t6_empty", s_empty, 1'b1);
    chk("t6_full", s_full, 1'b0);
    chk("t6_pc", s_pc, 32'h0);
    chk("t6_instr", s_instr, 32'h0);
    chk("t6_req", s_req, 1'b1);
    chk("t6_addr", s_addr, 32'h0);

    // randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 499) == 0);
      stall_i       = ($urandom_range(0, 7) == 0);
      redirect_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = $urandom;
      ready_i       = ($urandom_range(0, 3) != 0);
      imem_ready_i  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined RV32I core. It generalises the single-cycle PC/inc_PC/next_PC path.
- Owns the PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words in a DEPTH-entry prefetch FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (taken branch, jal, jalr) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DW, 32, instruction/address width.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0, PC loaded on reset.
- INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_o  out  1  request valid
- imem_addr_o  out  DW  request address
- imem_ready_i  in  1  memory accepts request this cycle (request fires when req & ready)
- imem_rvalid_i  in  1  response valid; responses in request order, latency >=1, no backpressure
- imem_rdata_i  in  DW  response instruction
- redirect_i  in  1  redirect fetch this cycle
- redirect_pc_i  in  DW  redirect target
- stall_i  in  1  freeze new request issue (for example, a debug halt)
- valid_o  out  1  instr_o/pc_o valid to decode
- ready_i  in  1  decode accepts (pops when valid_o & ready_i)
- instr_o  out  DW  instruction at FIFO head
- pc_o  out  DW  address of instr_o
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO count == DEPTH

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - PC=RESET_PC; FIFO count=0; outstanding=0; discard=0.
  - Outputs: imem_req_o=0, valid_o=0, empty_o=1, full_o=0, instr_o=0, pc_o=0.
  - Reset overrides redirect. Responses arriving in the first cycle after reset are ignored; memory is also reset.
- Issue:
  - imem_req_o=1 when: not rst, not stall_i, not redirect_i, and (count + outstanding) < DEPTH (credit reservation, so the FIFO never overflows).
  - imem_addr_o=PC.
  - On fire: PC<=PC+INC (modulo 2^DW, wraps silently); outstanding++.
  - Each FIFO entry also stores the PC it was fetched from. A small PC queue of depth DEPTH tracks in-flight addresses.
- Response:
  - On imem_rvalid_i: outstanding-- (a fire in the same cycle is counted in parallel).
  - If discard>0: word dropped, discard--.
  - Else: {pc, rdata} pushed to the FIFO tail.
- Output:
  - valid_o = !empty. instr_o/pc_o come from the FIFO head, combinationally.
  - Pop on valid_o & ready_i.
  - Latency: memory latency L yields valid_o at earliest L cycles after request fire, plus 1 cycle (registered push).
- Simultaneous events:
  - A push and a pop in the same cycle leave count unchanged; full FIFO push+pop is legal.
  - Response push into an empty FIFO is not bypassed; valid_o rises the next cycle.
- Redirect (priority over everything except rst):
  - Same edge: FIFO cleared (count=0, pop ignored), PC<=redirect_pc_i, discard<=outstanding_next (all in-flight responses excluding one consumed this cycle), no request issued that cycle.
  - Next cycle: issue resumes from the target.
  - redirect_pc_i[1:0]!=0 is passed through unchanged; alignment is decode's concern.
  - Back-to-back redirects: each one recomputes discard from the current outstanding.
- stall_i blocks issue only. Responses still land and decode may still pop.
- Invariant: count + outstanding <= DEPTH; discard <= outstanding.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds ports:
  - fetched_cnt_o (out, 32): increments on every FIFO pop.
  - discarded_cnt_o (out, 32): increments on every dropped response.
  - redirect_cnt_o (out, 32): increments on every redirect.
- All three reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset then 1-cycle memory, ready_i=1 -> pc_o sequence 0,4,8,12 with matching instr_o; valid_o first high 2 cycles after the first fire.
- ready_i=0 with DEPTH=4 -> exactly 4 requests issued (0..12), full_o=1, imem_req_o=0; restoring ready_i drains 0,4,8,12 in order and issue resumes at 16.
- Memory latency 3 with 2 requests outstanding, then redirect_i=1 with redirect_pc_i=32'h100 -> both stale responses dropped (discarded_cnt_o=2 with FETCH_PERF_EN); next pc_o=32'h100.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, no stale word ever appears, imem_addr_o=target.
- RESET_PC=32'hFFFFFFF8 -> pc_o sequence FFFFFFF8, FFFFFFFC, 00000000 (wrap).
- rst asserted mid-burst with 3 outstanding -> all outputs at reset values next cycle; first fetch from RESET_PC.
